// File: rtl/wb_pkg.sv
// ============================================================================
// Module   : wb_pkg
// Purpose  : Shared constants for the register-file writeback path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

`default_nettype wire

// File: rtl/load_data_align.sv
// ============================================================================
// Module   : load_data_align
// Purpose  : Combinational byte/half selection and extension of load data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_data_align
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] aligned
);

    logic [XLEN-1:0] w_sel;
    logic [15:0]     w_half;

    always_comb begin
        w_sel   = rdata >> {offset, 3'b000};
        // Half accesses use offset[1] only; a misaligned offset[0] is ignored.
        w_half  = offset[1] ? rdata[31:16] : rdata[15:0];
        aligned = rdata;
        case (funct3)
            F3_LB:   aligned = {{(XLEN-8){w_sel[7]}}, w_sel[7:0]};
            F3_LBU:  aligned = {{(XLEN-8){1'b0}}, w_sel[7:0]};
            F3_LH:   aligned = {{(XLEN-16){w_half[15]}}, w_half};
            F3_LHU:  aligned = {{(XLEN-16){1'b0}}, w_half};
            F3_LW:   aligned = rdata;
            default: aligned = rdata;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/regfile_writeback_unit.sv
// ============================================================================
// Module   : regfile_writeback_unit
// Purpose  : Merges ALU and load results into one registered RF write port and
//            tracks pending load destinations to stall decode on hazards.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_writeback_unit
    import wb_pkg::*;
#(
    parameter int MAX_LOADS = 2,
    parameter int XLEN      = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    input  logic            issue_is_load,
    input  logic [4:0]      issue_rd,
    output logic            issue_ready,
    input  logic [4:0]      src1_addr,
    input  logic [4:0]      src2_addr,
    output logic            stall,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [4:0]      ld_rd,
    input  logic [2:0]      ld_funct3,
    input  logic [1:0]      ld_offset,
    input  logic [XLEN-1:0] ld_rdata,
    output logic            rf_write_en,
    output logic [4:0]      rf_write_addr,
    output logic [XLEN-1:0] rf_write_data,
    output logic            loads_busy
);

    localparam int             CNT_W     = $clog2(MAX_LOADS + 1);
    localparam logic [CNT_W-1:0] C_MAX_CNT = CNT_W'(MAX_LOADS);

    logic [31:0]      r_pending;
    logic [CNT_W-1:0] r_outstanding;

    logic [31:0]      w_clear;
    logic [31:0]      w_set;
    logic [31:0]      w_pend_eff;
    logic             w_issue_fire;
    logic             w_load_issue;
    logic             w_ld_fire;
    logic [XLEN-1:0]  w_ld_aligned;

    load_data_align #(.XLEN(XLEN)) u_align (
        .funct3  (ld_funct3),
        .offset  (ld_offset),
        .rdata   (ld_rdata),
        .aligned (w_ld_aligned)
    );

    // A register stops stalling in the cycle its write is visible through the RF bypass.
    always_comb begin
        w_clear = '0;
        if (rf_write_en)
            w_clear[rf_write_addr] = 1'b1;
        w_pend_eff = r_pending & ~w_clear;
    end

    assign stall        = w_pend_eff[src1_addr] | w_pend_eff[src2_addr]
                        | (issue_valid & w_pend_eff[issue_rd]);
    assign issue_ready  = ~rst & ~stall & ~(issue_is_load & (r_outstanding == C_MAX_CNT));
    assign w_issue_fire = issue_valid & issue_ready;
    assign w_load_issue = w_issue_fire & issue_is_load;
    assign ld_ready     = ~rst & ~alu_valid;
    assign w_ld_fire    = ld_valid & ld_ready;
    assign loads_busy   = (r_outstanding != '0);

    always_comb begin
        w_set = '0;
        if (w_load_issue && issue_rd != REG_ZERO)
            w_set[issue_rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_write_en   <= 1'b0;
            rf_write_addr <= '0;
            rf_write_data <= '0;
            r_pending     <= '0;
            r_outstanding <= '0;
        end else begin
            if (alu_valid) begin
                rf_write_en   <= (alu_rd != REG_ZERO);
                rf_write_addr <= alu_rd;
                rf_write_data <= alu_data;
            end else if (w_ld_fire) begin
                rf_write_en   <= (ld_rd != REG_ZERO);
                rf_write_addr <= ld_rd;
                rf_write_data <= w_ld_aligned;
            end else begin
                rf_write_en   <= 1'b0;
            end

            r_pending <= w_pend_eff | w_set;

            case ({w_load_issue, w_ld_fire})
                2'b10: if (r_outstanding != C_MAX_CNT) r_outstanding <= r_outstanding + 1'b1;
                2'b01: if (r_outstanding != '0)        r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_ld_fire && ld_rd != REG_ZERO)
            assert (r_pending[ld_rd])
            else $error("load response to a register with no pending load: rd=%0d", ld_rd);
    end

endmodule

`default_nettype wire
